// File: rtl/mem_sdram_bridge_pkg.sv
// Shared definitions for the CPU-to-SDRAM-controller bridge.
// Holds the bridge state encoding, the RISC-V funct3 load/store size codes,
// the number of 16-bit beats per access and the alignment helpers.
package mem_sdram_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WBEAT0 = 3'd2,
        ST_WBEAT1 = 3'd3,
        ST_RWAIT  = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    localparam int BEAT_COUNT = 2;

    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size[1:0])
            SZ_H[1:0]: return addr_lo[0];
            SZ_W[1:0]: return (addr_lo != 2'b00);
            default:   return 1'b0;
        endcase
    endfunction

    // Drops the low address bits a halfword or word access is not allowed to use.
    function automatic logic [31:0] clear_misalign(input logic [2:0] size, input logic [31:0] addr);
        case (size[1:0])
            SZ_H[1:0]: return {addr[31:1], 1'b0};
            SZ_W[1:0]: return {addr[31:2], 2'b00};
            default:   return addr;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-result formatting for the SDRAM bridge (purely combinational).
// Ports:
//   lo_i       - first read halfword (beat 0)
//   hi_i       - second read halfword (beat 1)
//   size_i     - funct3 load size; bit 2 selects zero-extension
//   byte_sel_i - byte address bit 0, picks the byte lane of lo_i
//   data_o     - extended 32-bit load result
module mem_load_align
    import mem_sdram_bridge_pkg::*;
(
    input  logic [15:0] lo_i,
    input  logic [15:0] hi_i,
    input  logic [2:0]  size_i,
    input  logic        byte_sel_i,
    output logic [31:0] data_o
);

    logic [7:0] byte_v;

    always_comb begin
        byte_v = byte_sel_i ? lo_i[15:8] : lo_i[7:0];
        case (size_i[1:0])
            SZ_B[1:0]: data_o = size_i[2] ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            SZ_H[1:0]: data_o = size_i[2] ? {16'h0, lo_i}   : {{16{lo_i[15]}}, lo_i};
            default:   data_o = {hi_i, lo_i};
        endcase
    end

endmodule

// File: rtl/mem_sdram_bridge.sv
// Bridge between a single-outstanding CPU load/store port and a 16-bit SDRAM
// controller. Every access is two halfword beats; the controller's mc_act
// pulse moves the bridge out of its request phase.
//
// Optional feature macro: MEM_BRIDGE_MISALIGN_TRAP_EN
//   defined   - misaligned H/W accesses pulse cpu_err_o and are dropped
//   undefined - offending low address bits are cleared, cpu_err_o is 0
//
// Ports:
//   clk_i, reset_i            - clock, synchronous active-high reset
//   cpu_*_i / cpu_*_o         - CPU request, store data, load result, handshake
//   mc_addr_o .. mc_high_byte_o - request towards the SDRAM controller
//   mc_rd_data_i, mc_rd_valid_i - two-beat read return
//   mc_act_i, mc_init_i       - controller column-command pulse, init done
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | waiting for cpu_rd/cpu_wr
// ST_REQ    | request held to controller until mc_act
// ST_WBEAT0 | low write halfword on mc_wr_data
// ST_WBEAT1 | high write halfword on mc_wr_data
// ST_RWAIT  | collecting the two read beats
// ST_DONE   | cpu_ready pulse, result presented
module mem_sdram_bridge
    import mem_sdram_bridge_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] cpu_addr_i,
    input  logic        cpu_rd_i,
    input  logic        cpu_wr_i,
    input  logic [2:0]  cpu_size_i,
    input  logic [31:0] cpu_wdata_i,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_ready_o,
    output logic        cpu_busy_o,
    output logic        cpu_err_o,
    output logic [31:0] mc_addr_o,
    output logic        mc_rd_req_o,
    output logic        mc_wr_req_o,
    output logic [15:0] mc_wr_data_o,
    output logic [2:0]  mc_mem_size_o,
    output logic        mc_high_byte_o,
    input  logic [15:0] mc_rd_data_i,
    input  logic        mc_rd_valid_i,
    input  logic        mc_act_i,
    input  logic        mc_init_i
);

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    logic [2:0]  size_q;
    logic [31:0] wdata_q;
    logic        wr_q;
    logic        beat_q;
    logic [15:0] lo_q;
    logic [31:0] rdata_q;
    logic [31:0] load_data;
    logic        trap_hit;
    logic        accept;
    logic        last_beat;
    logic [15:0] wr_lo;

`ifdef MEM_BRIDGE_MISALIGN_TRAP_EN
    logic err_q;

    assign trap_hit = is_misaligned(cpu_size_i, cpu_addr_i[1:0]);

    always_ff @(posedge clk_i) begin
        if (reset_i) err_q <= 1'b0;
        else         err_q <= (state_q == ST_IDLE) && (cpu_wr_i || cpu_rd_i) && trap_hit;
    end

    assign cpu_err_o = err_q;
`else
    assign trap_hit  = 1'b0;
    assign cpu_err_o = 1'b0;
`endif

    assign accept    = (state_q == ST_IDLE) && (cpu_wr_i || cpu_rd_i) && !trap_hit;
    assign last_beat = (beat_q == 1'(BEAT_COUNT - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_REQ;
            // mc_init gating guards against a stray act before the controller is up.
            ST_REQ:    if (mc_act_i && mc_init_i) state_d = wr_q ? ST_WBEAT0 : ST_RWAIT;
            ST_WBEAT0: state_d = ST_WBEAT1;
            ST_WBEAT1: state_d = ST_DONE;
            ST_RWAIT:  if (mc_rd_valid_i && last_beat) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            beat_q  <= 1'b0;
            lo_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= clear_misalign(cpu_size_i, cpu_addr_i);
                size_q  <= cpu_size_i;
                wdata_q <= cpu_wdata_i;
                wr_q    <= cpu_wr_i;
                beat_q  <= 1'b0;
            end
            if (state_q == ST_RWAIT && mc_rd_valid_i) begin
                if (last_beat) begin
                    rdata_q <= load_data;
                end else begin
                    lo_q   <= mc_rd_data_i;
                    beat_q <= beat_q + 1'b1;
                end
            end
            if (state_q == ST_WBEAT1) rdata_q <= '0;
        end
    end

    // The high half comes straight from the bus so the result is ready on beat 1.
    mem_load_align u_load_align (
        .lo_i       (lo_q),
        .hi_i       (mc_rd_data_i),
        .size_i     (size_q),
        .byte_sel_i (addr_q[0]),
        .data_o     (load_data)
    );

    // Byte stores replicate the byte so the controller's byte mask picks the lane.
    assign wr_lo = (size_q[1:0] == SZ_B[1:0]) ? {2{wdata_q[7:0]}} : wdata_q[15:0];

    always_comb begin
        mc_wr_data_o = wr_lo;
        if (state_q == ST_WBEAT1 && size_q[1:0] != SZ_B[1:0]) mc_wr_data_o = wdata_q[31:16];
    end

    assign mc_addr_o      = {1'b0, addr_q[31:2], (addr_q[1] & (size_q[1:0] != SZ_W[1:0]))};
    assign mc_rd_req_o    = (state_q == ST_REQ) && !wr_q;
    assign mc_wr_req_o    = (state_q == ST_REQ) && wr_q;
    assign mc_mem_size_o  = {1'b0, size_q[1:0]};
    assign mc_high_byte_o = (size_q[1:0] == SZ_B[1:0]) ? addr_q[0] : 1'b0;
    assign cpu_busy_o     = (state_q != ST_IDLE);
    assign cpu_ready_o    = (state_q == ST_DONE);
    assign cpu_rdata_o    = rdata_q;

endmodule

// File: tb/tb_mem_sdram_bridge.sv
module tb_mem_sdram_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr;
    logic        cpu_rd, cpu_wr;
    logic [2:0]  cpu_size;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready, cpu_busy, cpu_err;
    logic [31:0] mc_addr;
    logic        mc_rd_req, mc_wr_req;
    logic [15:0] mc_wr_data;
    logic [2:0]  mc_mem_size;
    logic        mc_high_byte;
    logic [15:0] mc_rd_data;
    logic        mc_rd_valid, mc_act, mc_init;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    mem_sdram_bridge dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .cpu_addr_i     (cpu_addr),
        .cpu_rd_i       (cpu_rd),
        .cpu_wr_i       (cpu_wr),
        .cpu_size_i     (cpu_size),
        .cpu_wdata_i    (cpu_wdata),
        .cpu_rdata_o    (cpu_rdata),
        .cpu_ready_o    (cpu_ready),
        .cpu_busy_o     (cpu_busy),
        .cpu_err_o      (cpu_err),
        .mc_addr_o      (mc_addr),
        .mc_rd_req_o    (mc_rd_req),
        .mc_wr_req_o    (mc_wr_req),
        .mc_wr_data_o   (mc_wr_data),
        .mc_mem_size_o  (mc_mem_size),
        .mc_high_byte_o (mc_high_byte),
        .mc_rd_data_i   (mc_rd_data),
        .mc_rd_valid_i  (mc_rd_valid),
        .mc_act_i       (mc_act),
        .mc_init_i      (mc_init)
    );

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL reset ready: got %b want 0", cpu_ready); end
        vectors++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", cpu_busy); end
        vectors++; if (cpu_err !== 1'b0) begin errors++; $display("FAIL reset err: got %b want 0", cpu_err); end
        vectors++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset rdata: got %h want 0", cpu_rdata); end
        vectors++; if ({mc_rd_req, mc_wr_req, mc_high_byte} !== 3'b000) begin errors++; $display("FAIL reset mc ctl: got %b want 000", {mc_rd_req, mc_wr_req, mc_high_byte}); end
        vectors++; if (mc_addr !== 32'h0) begin errors++; $display("FAIL reset mc_addr: got %h want 0", mc_addr); end
        vectors++; if (mc_wr_data !== 16'h0) begin errors++; $display("FAIL reset wr_data: got %h want 0", mc_wr_data); end
        vectors++; if (mc_mem_size !== 3'h0) begin errors++; $display("FAIL reset mem_size: got %h want 0", mc_mem_size); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Starts and ends on a negedge with the bridge idle.
    task automatic do_write(input string name, input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] wdata, input logic also_rd, input logic [31:0] exp_addr,
                            input logic [15:0] exp_d0, input logic [15:0] exp_d1, input logic chk_d1,
                            input logic exp_hb);
        cpu_addr = addr; cpu_size = size; cpu_wdata = wdata; cpu_wr = 1'b1; cpu_rd = also_rd;
        @(negedge clk);
        cpu_wr = 1'b0; cpu_rd = 1'b0;
        vectors++; if ({mc_wr_req, mc_rd_req, cpu_busy} !== 3'b101) begin errors++; $display("FAIL %s req: got wr/rd/busy %b want 101", name, {mc_wr_req, mc_rd_req, cpu_busy}); end
        vectors++; if (mc_addr !== exp_addr) begin errors++; $display("FAIL %s mc_addr: got %h want %h", name, mc_addr, exp_addr); end
        vectors++; if (mc_high_byte !== exp_hb) begin errors++; $display("FAIL %s high_byte: got %b want %b", name, mc_high_byte, exp_hb); end
        vectors++; if (mc_mem_size !== {1'b0, size[1:0]}) begin errors++; $display("FAIL %s mem_size: got %h want %h", name, mc_mem_size, {1'b0, size[1:0]}); end
        vectors++; if (mc_wr_data !== exp_d0) begin errors++; $display("FAIL %s req wr_data: got %h want %h", name, mc_wr_data, exp_d0); end
        mc_act = 1'b1;
        @(negedge clk);
        mc_act = 1'b0;
        vectors++; if (mc_wr_req !== 1'b0) begin errors++; $display("FAIL %s req drop: got %b want 0", name, mc_wr_req); end
        vectors++; if (mc_wr_data !== exp_d0) begin errors++; $display("FAIL %s wbeat0: got %h want %h", name, mc_wr_data, exp_d0); end
        @(negedge clk);
        if (chk_d1) begin
            vectors++; if (mc_wr_data !== exp_d1) begin errors++; $display("FAIL %s wbeat1: got %h want %h", name, mc_wr_data, exp_d1); end
        end
        vectors++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL %s early ready: got %b want 0", name, cpu_ready); end
        @(negedge clk);
        vectors++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL %s ready: got %b want 1", name, cpu_ready); end
        vectors++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL %s wr rdata: got %h want 0", name, cpu_rdata); end
        @(negedge clk);
        vectors++; if ({cpu_ready, cpu_busy} !== 2'b00) begin errors++; $display("FAIL %s idle: got ready/busy %b want 00", name, {cpu_ready, cpu_busy}); end
    endtask

    task automatic do_read(input string name, input logic [31:0] addr, input logic [2:0] size,
                           input logic [15:0] beat0, input logic [15:0] beat1,
                           input logic [31:0] exp_addr, input logic exp_hb, input logic [31:0] exp_data);
        cpu_addr = addr; cpu_size = size; cpu_rd = 1'b1;
        @(negedge clk);
        cpu_rd = 1'b0;
        vectors++; if ({mc_rd_req, mc_wr_req, cpu_busy} !== 3'b101) begin errors++; $display("FAIL %s req: got rd/wr/busy %b want 101", name, {mc_rd_req, mc_wr_req, cpu_busy}); end
        vectors++; if (mc_addr !== exp_addr) begin errors++; $display("FAIL %s mc_addr: got %h want %h", name, mc_addr, exp_addr); end
        vectors++; if (mc_high_byte !== exp_hb) begin errors++; $display("FAIL %s high_byte: got %b want %b", name, mc_high_byte, exp_hb); end
        mc_act = 1'b1;
        @(negedge clk);
        mc_act = 1'b0;
        vectors++; if (mc_rd_req !== 1'b0) begin errors++; $display("FAIL %s req drop: got %b want 0", name, mc_rd_req); end
        @(negedge clk);
        mc_rd_valid = 1'b1; mc_rd_data = beat0;
        @(negedge clk);
        mc_rd_data = beat1;
        vectors++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL %s early ready: got %b want 0", name, cpu_ready); end
        @(negedge clk);
        mc_rd_valid = 1'b0; mc_rd_data = 16'h0;
        vectors++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL %s ready: got %b want 1", name, cpu_ready); end
        vectors++; if (cpu_rdata !== exp_data) begin errors++; $display("FAIL %s rdata: got %h want %h", name, cpu_rdata, exp_data); end
        @(negedge clk);
        vectors++; if ({cpu_ready, cpu_busy} !== 2'b00) begin errors++; $display("FAIL %s idle: got ready/busy %b want 00", name, {cpu_ready, cpu_busy}); end
    endtask

    task automatic test_store_word();
        do_write("sw", 32'h100, 3'b010, 32'hDEADBEEF, 1'b0, 32'h80, 16'hBEEF, 16'hDEAD, 1'b1, 1'b0);
    endtask

    task automatic test_loads();
        do_read("lw",  32'h100, 3'b010, 16'hBEEF, 16'hDEAD, 32'h80, 1'b0, 32'hDEADBEEF);
        do_read("lb",  32'h101, 3'b000, 16'h80FF, 16'h1111, 32'h80, 1'b1, 32'hFFFFFF80);
        do_read("lbu", 32'h101, 3'b100, 16'h80FF, 16'h1111, 32'h80, 1'b1, 32'h00000080);
        do_read("lb0", 32'h104, 3'b000, 16'h80FF, 16'h1111, 32'h82, 1'b0, 32'hFFFFFFFF);
        do_read("lh",  32'h102, 3'b001, 16'h8001, 16'h2222, 32'h81, 1'b0, 32'hFFFF8001);
        do_read("lhu", 32'h102, 3'b101, 16'h8001, 16'h2222, 32'h81, 1'b0, 32'h00008001);
    endtask

    task automatic test_back_to_back();
        do_write("sb_pri", 32'h103, 3'b000, 32'h0000005A, 1'b1, 32'h81, 16'h5A5A, 16'h0, 1'b0, 1'b1);
        do_read("b2b_lw", 32'h200, 3'b010, 16'h3344, 16'h1122, 32'h100, 1'b0, 32'h11223344);
    endtask

    task automatic test_init_wait();
        int held_bad = 0;
        mc_init = 1'b0;
        cpu_addr = 32'h400; cpu_size = 3'b010; cpu_rd = 1'b1;
        @(negedge clk);
        cpu_rd = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if ({mc_rd_req, cpu_busy, cpu_ready} !== 3'b110) held_bad++;
            @(negedge clk);
        end
        vectors++; if (held_bad !== 0) begin errors++; $display("FAIL init_hold: got %0d bad cycles want 0", held_bad); end
        mc_init = 1'b1;
        mc_act = 1'b1;
        @(negedge clk);
        mc_act = 1'b0;
        vectors++; if (mc_rd_req !== 1'b0) begin errors++; $display("FAIL init req drop: got %b want 0", mc_rd_req); end
        mc_rd_valid = 1'b1; mc_rd_data = 16'h1234;
        @(negedge clk);
        mc_rd_data = 16'h5678;
        @(negedge clk);
        mc_rd_valid = 1'b0; mc_rd_data = 16'h0;
        vectors++; if ({cpu_ready, cpu_rdata} !== {1'b1, 32'h56781234}) begin errors++; $display("FAIL init done: got %b %h want 1 56781234", cpu_ready, cpu_rdata); end
        @(negedge clk);
        vectors++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL init idle: got busy %b want 0", cpu_busy); end
    endtask

    task automatic test_misalign();
`ifdef MEM_BRIDGE_MISALIGN_TRAP_EN
        cpu_addr = 32'h102; cpu_size = 3'b010; cpu_rd = 1'b1;
        @(negedge clk);
        cpu_rd = 1'b0;
        vectors++; if ({cpu_err, mc_rd_req, cpu_busy} !== 3'b100) begin errors++; $display("FAIL trap: got err/rd/busy %b want 100", {cpu_err, mc_rd_req, cpu_busy}); end
        @(negedge clk);
        vectors++; if ({cpu_err, mc_rd_req, cpu_busy, cpu_ready} !== 4'b0000) begin errors++; $display("FAIL trap after: got %b want 0000", {cpu_err, mc_rd_req, cpu_busy, cpu_ready}); end
`else
        do_read("lw_mis", 32'h102, 3'b010, 16'hBEEF, 16'hDEAD, 32'h80, 1'b0, 32'hDEADBEEF);
        vectors++; if (cpu_err !== 1'b0) begin errors++; $display("FAIL mis err: got %b want 0", cpu_err); end
`endif
    endtask

    task automatic test_reset_mid();
        int ready_seen = 0;
        cpu_addr = 32'h300; cpu_size = 3'b010; cpu_wdata = 32'h11112222; cpu_wr = 1'b1;
        @(negedge clk);
        cpu_wr = 1'b0;
        mc_act = 1'b1;
        @(negedge clk);
        mc_act = 1'b0;
        vectors++; if (mc_wr_data !== 16'h2222) begin errors++; $display("FAIL rst_mid wbeat0: got %h want 2222", mc_wr_data); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++; if ({cpu_busy, cpu_ready, mc_wr_req, mc_rd_req, cpu_err} !== 5'b0) begin errors++; $display("FAIL rst_mid ctl: got %b want 00000", {cpu_busy, cpu_ready, mc_wr_req, mc_rd_req, cpu_err}); end
        vectors++; if ({mc_addr, mc_wr_data, cpu_rdata} !== 80'h0) begin errors++; $display("FAIL rst_mid data: got %h %h %h want 0", mc_addr, mc_wr_data, cpu_rdata); end
        for (int i = 0; i < 4; i++) begin
            if (cpu_ready !== 1'b0) ready_seen++;
            @(negedge clk);
        end
        vectors++; if (ready_seen !== 0) begin errors++; $display("FAIL rst_mid ready: got %0d pulses want 0", ready_seen); end
        do_read("rst_lw", 32'h100, 3'b010, 16'hBEEF, 16'hDEAD, 32'h80, 1'b0, 32'hDEADBEEF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_size = '0; cpu_wdata = '0;
        mc_rd_data = '0; mc_rd_valid = 1'b0; mc_act = 1'b0; mc_init = 1'b1;
        test_reset();
        test_store_word();
        test_loads();
        test_back_to_back();
        test_init_wait();
        test_misalign();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mem_sdram_bridge.md
MEM_SDRAM_BRIDGE -- requirements
Module: mem_sdram_bridge

Interface
REQ-001 clk  in  1  system clock; the SDRAM device clock is its inverse, generated downstream.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 cpu_addr  in  32  byte address, sampled on accept.
REQ-004 cpu_rd  in  1  read request, sampled only while cpu_busy=0.
REQ-005 cpu_wr  in  1  write request, sampled only while cpu_busy=0; wins over cpu_rd if both are high.
REQ-006 cpu_size  in  3  RISC-V funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 cpu_wdata  in  32  store data, right-aligned, sampled on accept.
REQ-008 cpu_rdata  out  32  load result, extended, valid in the cpu_ready cycle.
REQ-009 cpu_ready  out  1  one-cycle completion pulse.
REQ-010 cpu_busy  out  1  high from the cycle after accept through the cpu_ready cycle.
REQ-011 cpu_err  out  1  one-cycle misalignment pulse.
REQ-012 mc_addr  out  32  halfword address: {1'b0, cpu_addr[31:1]}, with bit0 forced to 0 for W.
REQ-013 mc_rd_req / mc_wr_req  out  1 each  controller request, level-held.
REQ-014 mc_wr_data  out  16  write halfword.
REQ-015 mc_mem_size  out  3  cpu_size[1:0] zero-extended.
REQ-016 mc_high_byte  out  1  cpu_addr[0] for byte accesses, else 0.
REQ-017 mc_rd_data  in  16  read halfword.
REQ-018 mc_rd_valid  in  1  high for exactly 2 consecutive cycles: beat0 then beat1.
REQ-019 mc_act  in  1  one-cycle pulse when the controller enters its column-command state.
REQ-020 mc_init  in  1  controller initialisation complete.

Function
REQ-021 States SHALL be IDLE, REQ, WBEAT0, WBEAT1, RWAIT, DONE.
REQ-022 IDLE: on cpu_wr or cpu_rd, the block SHALL latch address, size and data and enter REQ.
REQ-023 REQ: the block SHALL hold mc_*_req high until mc_act=1; mc_*_req SHALL be low from the cycle after mc_act.
REQ-024 Requests raised while mc_init=0 SHALL remain pending in REQ; there is no timeout.
REQ-025 Write, after mc_act: WBEAT0, then WBEAT1, then DONE.
REQ-026 Write data: mc_wr_data SHALL be cpu_wdata[15:0] from the REQ entry through WBEAT0, and cpu_wdata[31:16] in WBEAT1.
REQ-027 Write lane steering: for B, mc_wr_data SHALL carry the byte replicated in both lanes.
REQ-028 Read, after mc_act: RWAIT; the first mc_rd_valid cycle captures the low half, the second captures the high half, then DONE.
REQ-029 Read formatting: B/BU selects byte cpu_addr[0] of the low half; H/HU uses the low half; sign-extend when cpu_size[2]=0, zero-extend when cpu_size[2]=1; W returns {high, low}.
REQ-030 DONE SHALL pulse cpu_ready for 1 cycle, register cpu_rdata (0 for writes), and return to IDLE.
REQ-031 A new accept is legal in the cycle after DONE; the controller's precharge is absorbed by waiting in REQ.
REQ-032 Latency: word read cpu_ready = cycle after the second mc_rd_valid; write cpu_ready = cycle after WBEAT1.

Reset
REQ-033 Reset SHALL force IDLE, with all outputs 0 and mc_wr_data=0.
REQ-034 Reset SHALL take effect mid-transaction with no cpu_ready pulse.

Configuration
REQ-035 MEM_BRIDGE_MISALIGN_TRAP_EN defined: H with addr[0]=1, or W with addr[1:0]!=0, SHALL pulse cpu_err the cycle after accept, make no SDRAM request, and return to IDLE.
REQ-036 MEM_BRIDGE_MISALIGN_TRAP_EN undefined: offending low bits SHALL be cleared, the access SHALL proceed, and cpu_err SHALL be tied 0.

Structure
REQ-037 A shared package SHALL hold the state enum, the funct3 size constants and the beat count (2).
REQ-038 One sub-module, mem_load_align, SHALL contain the REQ-029 read-formatting logic combinationally.

Verification
REQ-039 SW 0xDEADBEEF @0x100 -> mc_addr=0x80; mc_wr_data=0xBEEF in WBEAT0 and 0xDEAD in WBEAT1; 1 cpu_ready.
REQ-040 LW @0x100 with beats 0xBEEF, 0xDEAD -> cpu_rdata=0xDEADBEEF; cpu_ready in the cycle after beat1.
REQ-041 LB @0x101, beat0=0x80FF -> cpu_rdata=0xFFFFFF80, mc_high_byte=1; LBU -> 0x00000080.
REQ-042 Request with mc_init=0 for 50 cycles, then 1 -> req held, single mc_act, correct completion.
REQ-043 LW @0x102 -> with macro: cpu_err pulse, no mc_rd_req; without macro: mc_addr=0x80 and normal read.
REQ-044 reset asserted during WBEAT0 -> IDLE next cycle, outputs 0, no cpu_ready; the next LW completes normally.
